// File: rtl/dmem_be.sv
// Byte-enable data memory with post-reset zero sweep.
// One-cycle read latency; out-of-range accesses report err.
module dmem_be #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W-1:0]   wd,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rd,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEP_A = (ADDR_W + 1)'(DEPTH);
  localparam logic NO_CLR = (CLEAR_ON_RESET == 0);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [IW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          acc;
  logic          inr;
  logic          sweep;
  logic [IW-1:0] idx;

  // Without a sweep the block is usable as soon as reset lifts.
  assign ready = rst_n & ((state == RUN) | NO_CLR);
  assign sweep = rst_n & (state == CLEAR) & ~NO_CLR;
  assign inr   = {1'b0, a} < DEP_A;
  assign idx   = a[IW-1:0];
  assign acc   = req & ready;

  // Storage has no reset: only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[cnt] <= '0;
    end else if (acc & we & inr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      cnt    <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rd     <= '0;
    end else begin
      rvalid <= acc & ~we;
      err    <= acc & ~inr;
      if (acc & ~we) rd <= inr ? mem[idx] : '0;
      case (state)
        CLEAR: begin
          if (NO_CLR) begin
            state <= RUN;
          end else if (cnt == LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_be.sv
// Bench for dmem_be: sweeping 16-word and non-sweeping 12-word
// instances driven in lockstep against a behavioural model.
module tb_dmem_be;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [15:0] a;
  logic [31:0] wd;
  logic        ready [2];
  logic        rvalid [2];
  logic        err [2];
  logic [31:0] rd [2];

  dmem_be #(.DATA_W(32), .ADDR_W(16), .DEPTH(16), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rstn[0]), .req(req), .we(we), .be(be), .a(a),
    .wd(wd), .ready(ready[0]), .rvalid(rvalid[0]), .rd(rd[0]), .err(err[0])
  );

  dmem_be #(.DATA_W(32), .ADDR_W(16), .DEPTH(12), .CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .rst_n(rstn[1]), .req(req), .we(we), .be(be), .a(a),
    .wd(wd), .ready(ready[1]), .rvalid(rvalid[1]), .rd(rd[1]), .err(err[1])
  );

  int          dep [2] = '{16, 12};
  logic [31:0] mm [2][16];
  int          clr [2];
  logic        erv [2];
  logic        eer [2];
  logic [31:0] erd [2];
  int          checks = 0;
  int          errors = 0;

  function automatic bit mrdy(int d);
    return (rstn[d] === 1'b1) && clr[d] == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.d%0d.ready", tag, d), {31'b0, ready[d]},
          {31'b0, mrdy(d)});
      chk($sformatf("%s.d%0d.rvalid", tag, d), {31'b0, rvalid[d]},
          {31'b0, erv[d]});
      chk($sformatf("%s.d%0d.err", tag, d), {31'b0, err[d]},
          {31'b0, eer[d]});
      chk($sformatf("%s.d%0d.rd", tag, d), rd[d], erd[d]);
    end
  endtask

  // One clock: apply request, advance model by one edge, compare.
  task automatic cyc(input logic r, input logic w, input logic [3:0] b,
                     input logic [15:0] ad, input logic [31:0] dat,
                     input string tag);
    bit acc;
    bit inr;
    req = r; we = w; be = b; a = ad; wd = dat;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc = r && mrdy(d);
      inr = int'(ad) < dep[d];
      if (rstn[d] === 1'b1 && clr[d] > 0) begin
        clr[d]--;
        if (clr[d] == 0) for (int k = 0; k < 16; k++) mm[d][k] = '0;
      end
      erv[d] = acc && !w;
      eer[d] = acc && !inr;
      if (acc && !w) erd[d] = inr ? mm[d][ad[3:0]] : 32'h0;
      if (acc && w && inr)
        for (int i = 0; i < 4; i++)
          if (b[i]) mm[d][ad[3:0]][8*i +: 8] = dat[8*i +: 8];
    end
    #1;
    chk_all(tag);
  endtask

  task automatic set_rst(input int d, input logic v, input string tag);
    rstn[d] = v;
    if (!v) begin
      clr[d] = (d == 0) ? 16 : 0;
      erv[d] = 1'b0;
      eer[d] = 1'b0;
      erd[d] = '0;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 4'h0, 16'h0, 32'h0, tag);
  endtask

  initial begin
    req = 0; we = 0; be = 0; a = 0; wd = 0;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    #2;
    rstn[0] = 1'b0;
    set_rst(1, 1'b0, "por");
    set_rst(0, 1'b0, "por");
    idle("in_rst");
    idle("in_rst");
    @(negedge clk);
    rstn[1] = 1'b1;
    set_rst(0, 1'b1, "release");

    // Sweep on u0 ignores these; u1 takes them as its initial contents.
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 1'b1, 4'hf, 16'(k), $urandom, "sweep_fill");
    cyc(1'b1, 1'b1, 4'hf, 16'd20, 32'h0, "sweep_oor");
    chk("sweep_done_ready", {31'b0, ready[0]}, 32'h1);

    for (int k = 0; k < 16; k++)
      cyc(1'b1, 1'b0, 4'h0, 16'(k), 32'h0, "read_zero");
    idle("hold");

    cyc(1'b1, 1'b1, 4'hf, 16'd3, 32'hAABBCCDD, "bw_full");
    cyc(1'b1, 1'b1, 4'h5, 16'd3, 32'h11223344, "bw_part");
    cyc(1'b1, 1'b0, 4'h0, 16'd3, 32'h0, "bw_read");
    chk("bw_value", rd[0], 32'hAA22CC44);
    idle("bw_hold");
    chk("bw_hold_rd", rd[0], 32'hAA22CC44);

    for (int k = 1; k <= 3; k++)
      cyc(1'b1, 1'b1, 4'hf, 16'(k), 32'(k), "b2b_wr");
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 1'b0, 4'h0, 16'(k), 32'h0, "b2b_rd");
      chk("b2b_val", rd[0], 32'(k));
    end

    cyc(1'b1, 1'b1, 4'h0, 16'd5, 32'hFFFFFFFF, "be_zero_wr");
    cyc(1'b1, 1'b1, 4'hf, 16'd20, 32'hDEADBEEF, "oor_wr");
    cyc(1'b1, 1'b0, 4'h0, 16'd16, 32'h0, "oor_rd");
    chk("oor_rd_err", {31'b0, err[0]}, 32'h1);
    chk("oor_rd_rd", rd[0], 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 16'd5, 32'h0, "be_zero_rd");
    cyc(1'b1, 1'b0, 4'h0, 16'd15, 32'h0, "edge_rd15");
    cyc(1'b1, 1'b0, 4'h0, 16'd12, 32'h0, "edge_rd12");
    cyc(1'b1, 1'b0, 4'h0, 16'd11, 32'h0, "edge_rd11");

    // Reset with a read response on the outputs, then abort a sweep.
    cyc(1'b1, 1'b1, 4'hf, 16'd9, 32'h12345678, "pend_wr");
    cyc(1'b1, 1'b0, 4'h0, 16'd9, 32'h0, "pend_rd");
    set_rst(0, 1'b0, "pend_rst");
    idle("pend_in_rst");
    @(negedge clk);
    set_rst(0, 1'b1, "pend_rel");
    for (int k = 0; k < 7; k++)
      cyc(1'b1, 1'b0, 4'h0, 16'(k), 32'h0, "sweep_part");
    set_rst(0, 1'b0, "abort_rst");
    @(negedge clk);
    set_rst(0, 1'b1, "abort_rel");
    for (int k = 0; k < 16; k++) idle("resweep");
    cyc(1'b1, 1'b0, 4'h0, 16'd9, 32'h0, "resweep_rd");
    chk("resweep_zero", rd[0], 32'h0);

    set_rst(1, 1'b0, "u1_rst");
    idle("u1_in_rst");
    @(negedge clk);
    set_rst(1, 1'b1, "u1_rel");
    for (int k = 0; k < 12; k++)
      cyc(1'b1, 1'b0, 4'h0, 16'(k), 32'h0, "u1_keep");

    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          4'($urandom), 16'($urandom_range(0, 19)), $urandom, "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_be.md
DMEM_BE -- requirements
Module: dmem_be

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16: word-address width.
REQ-003 Parameter DEPTH, default 1024: number of words; SHALL be at most 2**ADDR_W and need not be a power of two.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 enables the post-reset zero sweep, 0 skips it.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  transaction request; accepted when req=1 and ready=1 at a rising edge.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 be  input  DATA_W/8  byte enables for writes; bit i covers wd[8i+7:8i]; ignored on reads.
REQ-010 a  input  ADDR_W  word address.
REQ-011 wd  input  DATA_W  write data.
REQ-012 ready  output  1  block can accept a transaction this cycle.
REQ-013 rvalid  output  1  one-cycle pulse: rd carries read data.
REQ-014 rd  output  DATA_W  registered read data.
REQ-015 err  output  1  one-cycle pulse: the previous accepted transaction had an out-of-range address.

Function
REQ-016 The block SHALL have two states, CLEAR and RUN.
REQ-017 On reset release, the block SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-018 In CLEAR, the block SHALL write all-zero to word k at clock edge k (k = 0..DEPTH-1), hold ready=0, ignore req, and enter RUN at the edge that clears word DEPTH-1.
REQ-019 A sweep SHALL take exactly DEPTH cycles, and ready SHALL go to 1 in the cycle after the last word is cleared.
REQ-020 In RUN, ready SHALL be 1 in every cycle.
REQ-021 On an accepted write with a < DEPTH, only the bytes with be[i]=1 SHALL be updated at that edge; be=0 leaves memory unchanged and is not an error.
REQ-022 On an accepted read with a < DEPTH, rd SHALL hold mem[a] and rvalid SHALL be 1 in the following cycle (latency 1).
REQ-023 A read accepted in the cycle after a write to the same address SHALL return the newly written bytes.
REQ-024 Back-to-back reads SHALL be accepted every cycle, and rvalid SHALL stay high across consecutive reads.
REQ-025 rd SHALL hold its last value when rvalid=0.
REQ-026 An accepted transaction with a >= DEPTH SHALL NOT modify memory and SHALL pulse err for one cycle, one cycle after acceptance.
REQ-027 An out-of-range read SHALL additionally pulse rvalid with rd = 0.
REQ-028 When no transaction is accepted, rvalid and err SHALL be 0 in the next cycle.
REQ-029 rst_n SHALL NOT reset memory contents; only the CLEAR sweep zeroes memory.
REQ-030 Assertion of rst_n during a sweep SHALL abort the sweep, and the sweep SHALL restart from word 0 after release.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force ready=0, rvalid=0, err=0, rd=0, the sweep counter to 0 and the state to CLEAR, independent of clk.
REQ-032 An in-flight read response SHALL be discarded by reset, with no rvalid pulse after release.

Verification
REQ-033 DEPTH=16, CLEAR_ON_RESET=1, release rst_n -> ready=0 for exactly 16 cycles, then 1; subsequent reads of addresses 0..15 return 0.
REQ-034 Write a=3, wd=32'hAABBCCDD, be=4'b1111; next cycle write a=3, wd=32'h11223344, be=4'b0101; next cycle read a=3 -> one cycle later rvalid=1, rd=32'hAA22CC44.
REQ-035 Reads of a=1,2,3 on three consecutive cycles (contents 1,2,3) -> rvalid high for 3 consecutive cycles, rd = 1, 2, 3 in order.
REQ-036 DEPTH=16: write a=20 -> err pulses one cycle later and memory is unchanged; read a=16 -> rvalid=1, err=1, rd=0.
REQ-037 Assert rst_n=0 at sweep word 7 with a read response pending -> ready, rvalid, err and rd drop to 0 immediately; after release, the sweep restarts at word 0 and takes 16 full cycles.
REQ-038 CLEAR_ON_RESET=0: after reset release, ready=1 on the first cycle and previously written data is preserved across the reset.
